// File: rtl/freq_divider_multi.sv
// freq_divider_multi
// ------------------
// Multi-channel clock divider. Each channel counts system-clock cycles and
// toggles its divided clock every div+1 enabled cycles, emitting a one-cycle
// tick on the same edge. Divisors are written into a per-channel shadow
// register and only become active when the channel wraps (count == 0 at the
// next edge), so a divisor change can never skip the terminal count or make
// the counter run past it. A sync strobe restarts every channel in phase and
// applies any waiting shadow divisor immediately.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   en         per-channel count enable
//   sync       restart all channels in phase (one-cycle strobe)
//   load       divisor write strobe (one-cycle)
//   load_ch    channel index for load; indices >= N_CH are ignored
//   load_div   divisor value for load
//   clock_div  divided clocks (registered)
//   tick       one-cycle pulse per clock_div toggle (registered)
//   pending    a shadow divisor is waiting for the channel's next wrap
//
// Strobe semantics: sync and load are sampled on every rising edge and act
// exactly once per cycle they are high; there is no back-pressure.
module freq_divider_multi #(
  parameter int          N_CH        = 2,
  parameter int          CNT_W       = 32,
  parameter logic [31:0] DEFAULT_DIV = 32'd25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             load,
  input  logic [2:0]       load_ch,
  input  logic [CNT_W-1:0] load_div,
  output logic [N_CH-1:0]  clock_div,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] count [N_CH];
  logic [CNT_W-1:0] div   [N_CH];
  logic [CNT_W-1:0] shd   [N_CH];
  logic [N_CH-1:0]  load_hit;

  // One-hot decode of the load target; out-of-range indices match nothing.
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      load_hit[i] = load && (int'(load_ch) == i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        count[i] <= '0;
        div[i]   <= DEF_DIV;
        shd[i]   <= DEF_DIV;
      end
      pending   <= '0;
      clock_div <= '0;
      tick      <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync) begin
          // Restart in phase. A load in the same cycle bypasses the shadow
          // and becomes the active divisor straight away.
          count[i]     <= '0;
          clock_div[i] <= 1'b0;
          tick[i]      <= 1'b0;
          pending[i]   <= 1'b0;
          if (load_hit[i]) begin
            div[i] <= load_div;
            shd[i] <= load_div;
          end else if (pending[i]) begin
            div[i] <= shd[i];
          end
        end else begin
          if (en[i]) begin
            if (count[i] == div[i]) begin
              count[i]     <= '0;
              clock_div[i] <= ~clock_div[i];
              tick[i]      <= 1'b1;
              // Shadow is applied only here, while count restarts at 0.
              if (pending[i]) begin
                div[i]     <= shd[i];
                pending[i] <= 1'b0;
              end
            end else begin
              count[i] <= count[i] + CNT_W'(1);
              tick[i]  <= 1'b0;
            end
          end else begin
            tick[i] <= 1'b0;
          end
          // A load on the wrap edge lands after the old shadow was consumed
          // above, so the new value waits for the following wrap.
          if (load_hit[i]) begin
            shd[i]     <= load_div;
            pending[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_divider_multi.sv
// Testbench for freq_divider_multi (N_CH=2, CNT_W=8, DEFAULT_DIV=3).
// Reference model tracks, per channel, how many enabled cycles remain until
// the next toggle, plus the active/shadow divisors and pending flag.
module tb_freq_divider_multi;

  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int DEF   = 3;

  logic             clk;
  logic             reset;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             load;
  logic [2:0]       load_ch;
  logic [CNT_W-1:0] load_div;
  logic [N_CH-1:0]  clock_div;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  freq_divider_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_DIV(32'(DEF))
  ) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .load(load),
    .load_ch(load_ch), .load_div(load_div),
    .clock_div(clock_div), .tick(tick), .pending(pending)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N_CH-1:0] m_clk, m_tick, m_pend;
  int m_div [N_CH];
  int m_shd [N_CH];
  int m_rem [N_CH];   // enabled cycles left until next toggle

  task automatic model_reset();
    m_clk = '0; m_tick = '0; m_pend = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_div[i] = DEF; m_shd[i] = DEF; m_rem[i] = DEF + 1;
    end
  endtask

  task automatic model_step(input logic [1:0] e, input logic s, input logic l,
                            input logic [2:0] c, input logic [7:0] d);
    for (int i = 0; i < N_CH; i++) begin
      bit hit;
      hit = l && (int'(c) == i);
      if (s) begin
        m_clk[i] = 1'b0; m_tick[i] = 1'b0;
        if (hit) begin
          m_div[i] = int'(d); m_shd[i] = int'(d);
        end else if (m_pend[i]) begin
          m_div[i] = m_shd[i];
        end
        m_pend[i] = 1'b0;
        m_rem[i]  = m_div[i] + 1;
      end else begin
        m_tick[i] = 1'b0;
        if (e[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            m_clk[i]  = ~m_clk[i];
            m_tick[i] = 1'b1;
            if (m_pend[i]) begin
              m_div[i] = m_shd[i]; m_pend[i] = 1'b0;
            end
            m_rem[i] = m_div[i] + 1;
          end
        end
        if (hit) begin
          m_shd[i] = int'(d); m_pend[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("clock_div", 32'(clock_div), 32'(m_clk));
    chk("tick",      32'(tick),      32'(m_tick));
    chk("pending",   32'(pending),   32'(m_pend));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [1:0] e, input logic s, input logic l,
                       input logic [2:0] c, input logic [7:0] d);
    en = e; sync = s; load = l; load_ch = c; load_div = d;
    @(posedge clk);
    model_step(e, s, l, c, d);
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(2'b11, 1'b0, 1'b0, 3'd0, 8'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       ld;
    logic [1:0] e_clk;
    logic [1:0] e_tick;
    logic [1:0] e_pend;
  } vec_t;

  vec_t vecs [24];

  // Edge-by-edge expectation after reset release; load ch1<=1 on edge 13.
  task automatic fill_vecs();
    logic [1:0] clk_tab  [24];
    logic [1:0] tick_tab [24];
    clk_tab  = '{2'b00,2'b00,2'b00,2'b11,2'b11,2'b11,2'b11,2'b00,2'b00,2'b00,2'b00,2'b11,
                 2'b11,2'b11,2'b11,2'b00,2'b00,2'b10,2'b10,2'b01,2'b01,2'b11,2'b11,2'b00};
    tick_tab = '{2'b00,2'b00,2'b00,2'b11,2'b00,2'b00,2'b00,2'b11,2'b00,2'b00,2'b00,2'b11,
                 2'b00,2'b00,2'b00,2'b11,2'b00,2'b10,2'b00,2'b11,2'b00,2'b10,2'b00,2'b11};
    for (int k = 0; k < 24; k++) begin
      vecs[k].ld     = (k == 12);
      vecs[k].e_clk  = clk_tab[k];
      vecs[k].e_tick = tick_tab[k];
      vecs[k].e_pend = (k >= 12 && k <= 14) ? 2'b10 : 2'b00;
    end
  endtask

  // Wait up to budget cycles for tick[ch]; returns cycles taken or -1.
  task automatic cycles_to_tick(input int ch, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      idle(1);
      if (tick[ch]) begin
        n = k;
        break;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0, n1, got;
    int guard;
    reset = 1'b0; en = 2'b11; sync = 1'b0; load = 1'b0; load_ch = 3'd0; load_div = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_clock_div", 32'(clock_div), 32'd0);
    chk("reset_tick",      32'(tick),      32'd0);
    chk("reset_pending",   32'(pending),   32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven: reset timing and a divisor load on ch1.
    fill_vecs();
    for (int k = 0; k < 24; k++) begin
      cycle(2'b11, 1'b0, vecs[k].ld, 3'd1, 8'd1);
      chk($sformatf("vec%0d_clock_div", k + 1), 32'(clock_div), 32'(vecs[k].e_clk));
      chk($sformatf("vec%0d_tick", k + 1),      32'(tick),      32'(vecs[k].e_tick));
      chk($sformatf("vec%0d_pending", k + 1),   32'(pending),   32'(vecs[k].e_pend));
    end

    // Enable gating with div=0 on ch0.
    cycle(2'b11, 1'b0, 1'b1, 3'd0, 8'd0);
    idle(6);
    for (int k = 0; k < 5; k++) begin
      cycle(2'b10, 1'b0, 1'b0, 3'd0, 8'd0);
      chk("gated_tick0", 32'(tick[0]), 32'd0);
    end
    idle(4);

    // Out-of-range channel index: no state change.
    cycle(2'b11, 1'b0, 1'b1, 3'd5, 8'd9);
    chk("ch5_pending", 32'(pending), 32'd0);
    idle(3);

    // Sync with simultaneous load: ch0 div=3, ch1 div=5, then mid-count.
    cycle(2'b11, 1'b0, 1'b1, 3'd0, 8'd3);
    cycle(2'b11, 1'b0, 1'b1, 3'd1, 8'd5);
    cycle(2'b11, 1'b1, 1'b0, 3'd0, 8'd0);
    idle(2);
    cycle(2'b11, 1'b1, 1'b1, 3'd1, 8'd2);
    chk("sync_clock_div", 32'(clock_div), 32'd0);
    chk("sync_pending",   32'(pending),   32'd0);
    n0 = -1; n1 = -1;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (tick[0] && n0 < 0) n0 = k;
      if (tick[1] && n1 < 0) n1 = k;
    end
    chk("sync_first_tick_ch0", 32'(n0), 32'd4);
    chk("sync_first_tick_ch1", 32'(n1), 32'd3);

    // Load exactly on the wrap edge while an older value is pending.
    cycle(2'b11, 1'b0, 1'b1, 3'd1, 8'd4);
    guard = 0;
    while (m_rem[1] != 1 && guard < 20) begin
      idle(1);
      guard++;
    end
    chk("wrap_wait_bound", 32'(m_rem[1]), 32'd1);
    cycle(2'b11, 1'b0, 1'b1, 3'd1, 8'd2);
    chk("wrap_edge_tick1",    32'(tick[1]),    32'd1);
    chk("wrap_edge_pending1", 32'(pending[1]), 32'd1);
    cycles_to_tick(1, 20, got);
    chk("wrap_old_shd_halfperiod", 32'(got), 32'd5);
    cycles_to_tick(1, 20, got);
    chk("wrap_new_shd_halfperiod", 32'(got), 32'd3);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 6)));
    end

    // Asynchronous reset mid-run with a pending load.
    cycle(2'b11, 1'b0, 1'b1, 3'd1, 8'd7);
    idle(1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_clock_div", 32'(clock_div), 32'd0);
    chk("async_tick",      32'(tick),      32'd0);
    chk("async_pending",   32'(pending),   32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles_to_tick(0, 20, got);
    chk("post_reset_first_tick", 32'(got), 32'(DEF + 1));
    chk("post_reset_pending",    32'(pending), 32'd0);
    cycles_to_tick(1, 20, got);
    chk("post_reset_halfperiod", 32'(got), 32'(DEF + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_divider_multi.md
# freq_divider_multi

Parametrised multi-channel clock divider that produces per-channel toggling divided clocks and one-cycle tick strobes from the single system clock. Each channel's half-period is runtime-programmable through a shadowed divisor register, updated glitch-free at the channel's next wrap. Channels can be gated individually and phase-aligned together with a sync strobe. It replaces fixed-constant dividers in the traffic-light timing path, for example 1 Hz state timing plus a faster blink clock from one instance.

## Interface
- `N_CH`, default 2: number of independent channels (1..8).
- `CNT_W`, default 32: counter and divisor width.
- `DEFAULT_DIV`, default 32'd25000000: divisor loaded into every channel at reset. Truncated to `CNT_W`.

- `clk` input, 1: system clock. All logic is on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `en` input, `N_CH`: per-channel count enable.
- `sync` input, 1: one-cycle strobe that restarts all channels in phase.
- `load` input, 1: one-cycle divisor-write strobe.
- `load_ch` input, 3: target channel index for `load`.
- `load_div` input, `CNT_W`: divisor value for `load`.
- `clock_div` output, `N_CH`: divided clocks. Registered.
- `tick` output, `N_CH`: one-cycle pulse for each `clock_div` toggle. Registered.
- `pending` output, `N_CH`: a shadow divisor is waiting to be applied.

## Operation
- Per-channel state:
  - `count[CNT_W]`
  - active divisor `div[CNT_W]`
  - shadow divisor `shd[CNT_W]`
  - `pending` flag
  - `clock_div` bit
  - `tick` bit
- Reset (`reset`=0, asynchronous):
  - `count`=0, `div`=`shd`=`DEFAULT_DIV`.
  - `pending`=0, `clock_div`=0, `tick`=0.
- Counting, when `en[i]`=1 and `sync`=0:
  - If `count`==`div`: set `count`←0, toggle `clock_div`, set `tick`←1. If `pending`, also set `div`←`shd` and `pending`←0.
  - Otherwise: `count`←`count`+1, `tick`←0.
- Resulting timing: half-period = `div`+1 cycles and full period = 2·(`div`+1). `div`=0 gives clk/2.
- Hold, when `en[i]`=0:
  - `count`, `clock_div` and `div` hold.
  - `tick` is forced to 0.
  - A pending load stays pending.
- Load, when `load`=1:
  - If `load_ch` < `N_CH`: `shd[load_ch]`←`load_div`, `pending[load_ch]`←1.
  - If `load_ch` ≥ `N_CH`: the write is ignored.
  - A second load before the wrap overwrites `shd`. Only the last value is applied.
- Sync, when `sync`=1 (highest priority after reset), on all channels regardless of `en`:
  - `count`←0, `clock_div`←0, `tick`←0.
  - Any pending `shd` is copied to `div` and `pending` is cleared.
- Simultaneous `sync` and `load` in the same cycle: the loaded value goes directly to `div[load_ch]` and `pending` stays 0.
- Simultaneous `load` and wrap on the same channel:
  - The wrap applies the old `shd` if one was pending; otherwise `div` is unchanged.
  - The new value becomes `shd` with `pending`=1 and is applied at the following wrap.
- Counter arithmetic:
  - `count` never exceeds `div`.
  - The comparison is equality only.
  - A new `div` is only ever applied while `count`=0, so no overflow or skipped terminal count is possible.

## Timing
- `clock_div` and `tick` change on the same edge, the one that wraps `count`.
- `tick` is high for exactly one cycle per toggle.
- Reaction latencies:
  - `load` → `pending` visible: 1 cycle.
  - `load` → new divisor in effect: at the next wrap.
  - `sync` → all outputs 0: 1 cycle.
- After `sync`, the first toggle on channel i occurs `div[i]`+1 cycles later.
- After the asynchronous reset is released, the first toggle occurs at edge `DEFAULT_DIV`+1.
- Reset asserted mid-operation:
  - All outputs clear immediately, with no clock needed.
  - Pending loads are discarded.

## Test plan
- Reset values: `N_CH`=2, `DEFAULT_DIV`=3, `en`=2'b11. Release reset → both `clock_div` toggle every 4 cycles (period 8); `tick` pulses on edges 4, 8, 12.
- Divisor load: load ch1 with 1 while its `count`=1 → `pending[1]`=1 until the next wrap. After the wrap, ch1 half-period is 2 cycles; ch0 is unchanged at 4.
- Enable gating and `div`=0: set `div`=0 → ch0 toggles every cycle. Drop `en[0]` for 5 cycles → `clock_div[0]` and `count` frozen, `tick[0]`=0. Re-enable → toggling resumes at the same phase.
- Sync with simultaneous load: ch0 `div`=3, ch1 `div`=5, mid-count; assert `sync` and `load` (ch1, 2) in the same cycle → next cycle both `clock_div`=0 and `pending`=0. Ch0 toggles 4 cycles later, ch1 toggles 3 cycles later.
- Edge cases: load on the exact wrap edge → old `shd` applied, new value pending. `load_ch`=5 → no state change.
- Reset mid-run: assert `reset` between clock edges while pending=1 → outputs clear asynchronously. After release, `div` is back to `DEFAULT_DIV` and `pending`=0.
